// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified instruction/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } arb_gnt_t;

   // Width able to hold 0..max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      if (max_val > 0) begin
         return $clog2(max_val + 1);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Winner selection between fetch and data requests, with the starvation
// counter that forces a fetch grant after too many consecutive data wins.
module mem_arb_sel
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 2
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     if_req,
   input  logic     d_req,
   input  logic     arb_en,
   output arb_gnt_t gnt
);

   localparam int            CW      = cnt_width(STARVE_LIMIT);
   localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_q;
   logic [CW-1:0] starve_d;
   logic          force_if_s;

   // Pick the winner and work out the next starvation count.
   always_comb begin
      force_if_s = (STARVE_LIMIT != 0) && (starve_q == LIMIT_C);
      gnt        = GNT_IF;
      starve_d   = starve_q;
      if (d_req && !(if_req && force_if_s)) begin
         gnt = GNT_D;
      end else begin
         gnt = GNT_IF;
      end
      if (arb_en) begin
         if (gnt == GNT_IF) begin
            starve_d = {CW{1'b0}};
         end else if (if_req && (starve_q != LIMIT_C)) begin
            starve_d = starve_q + {{(CW-1){1'b0}}, 1'b1};
         end else begin
            starve_d = starve_q;
         end
      end else begin
         starve_d = starve_q;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q <= {CW{1'b0}};
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port fixed-latency memory between the fetch port and the
// load/store port: one transaction at a time, IDLE -> ISSUE -> WAIT -> DONE.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic                    if_ack,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [DATA_WIDTH/8-1:0] d_be,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   output logic                    d_ack,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    busy
);

   localparam int            BE_W       = DATA_WIDTH / 8;
   localparam int            LW         = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [LW-1:0] LAT_INIT_C = LW'(MEM_LATENCY - 1);

   arb_state_t            state_q, state_d;
   arb_gnt_t              gnt_q, gnt_d;
   arb_gnt_t              gnt_s;
   logic                  arb_en_s;
   logic [LW-1:0]         lat_q, lat_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [BE_W-1:0]       be_q, be_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

   assign arb_en_s = (state_q == IDLE) && (if_req || d_req);

   mem_arb_sel #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_sel (
      .clk    (clk),
      .reset  (reset),
      .if_req (if_req),
      .d_req  (d_req),
      .arb_en (arb_en_s),
      .gnt    (gnt_s)
   );

   // Next-state, request latch and read-data capture.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      lat_d      = lat_q;
      addr_d     = addr_q;
      we_d       = we_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (arb_en_s) begin
               gnt_d   = gnt_s;
               state_d = ISSUE;
               if (gnt_s == GNT_D) begin
                  addr_d  = d_addr;
                  we_d    = d_we;
                  be_d    = d_be;
                  wdata_d = d_wdata;
               end else begin
                  // A fetch is always a plain read, whatever the data port shows.
                  addr_d  = if_addr;
                  we_d    = 1'b0;
                  be_d    = {BE_W{1'b0}};
                  wdata_d = {DATA_WIDTH{1'b0}};
               end
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            lat_d   = LAT_INIT_C;
            state_d = WAIT;
         end
         WAIT: begin
            if (lat_q == {LW{1'b0}}) begin
               state_d = DONE;
               if (gnt_q == GNT_IF) begin
                  if_rdata_d = mem_rdata;
               end else if (!we_q) begin
                  d_rdata_d = mem_rdata;
               end else begin
                  d_rdata_d = d_rdata_q;
               end
            end else begin
               lat_d = lat_q - {{(LW-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, latch and read-data registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         gnt_q      <= GNT_IF;
         lat_q      <= {LW{1'b0}};
         addr_q     <= {ADDR_WIDTH{1'b0}};
         we_q       <= 1'b0;
         be_q       <= {BE_W{1'b0}};
         wdata_q    <= {DATA_WIDTH{1'b0}};
         if_rdata_q <= {DATA_WIDTH{1'b0}};
         d_rdata_q  <= {DATA_WIDTH{1'b0}};
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         lat_q      <= lat_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // Memory fields are gated so the bus reads all-zero outside ISSUE.
   assign mem_en    = (state_q == ISSUE);
   assign mem_we    = mem_en & we_q;
   assign mem_be    = mem_en ? be_q    : {BE_W{1'b0}};
   assign mem_addr  = mem_en ? addr_q  : {ADDR_WIDTH{1'b0}};
   assign mem_wdata = mem_en ? wdata_q : {DATA_WIDTH{1'b0}};
   assign if_ack    = (state_q == DONE) && (gnt_q == GNT_IF);
   assign d_ack     = (state_q == DONE) && (gnt_q == GNT_D);
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: instance A (latency 2, starve limit 2) and instance B
// (latency 1, starve limit 0), each with its own behavioural memory.
module tb_unified_mem_arbiter;

   logic clk;
   logic reset;
   int   compared;
   int   mismatched;

   logic        a_if_req, a_d_req, a_d_we;
   logic [9:0]  a_if_addr, a_d_addr, a_mem_addr;
   logic [3:0]  a_d_be, a_mem_be;
   logic [31:0] a_d_wdata, a_if_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
   logic        a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_busy;
   logic [31:0] a_pipe0, a_pipe1;
   logic [31:0] mem_a [0:1023];

   logic        b_if_req, b_d_req, b_d_we;
   logic [9:0]  b_if_addr, b_d_addr, b_mem_addr;
   logic [3:0]  b_d_be, b_mem_be;
   logic [31:0] b_d_wdata, b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
   logic        b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy;
   logic [31:0] b_pipe0;
   logic [31:0] mem_b [0:1023];

   unified_mem_arbiter #(
      .ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(2)
   ) u_a (
      .clk(clk), .reset(reset),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
      .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
      .d_ack(a_d_ack), .d_rdata(a_d_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
   );

   unified_mem_arbiter #(
      .ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(0)
   ) u_b (
      .clk(clk), .reset(reset),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
      .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
      .d_ack(b_d_ack), .d_rdata(b_d_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models: data appears exactly MEM_LATENCY cycles after mem_en, junk otherwise.
   always @(posedge clk) begin
      if (a_mem_en) begin
         if (a_mem_we) begin
            for (int k = 0; k < 4; k++) begin
               if (a_mem_be[k]) mem_a[a_mem_addr][8*k +: 8] <= a_mem_wdata[8*k +: 8];
            end
         end
         a_pipe0 <= mem_a[a_mem_addr];
      end else begin
         a_pipe0 <= 32'hBAD0_BAD0;
      end
      a_pipe1 <= a_pipe0;
      if (b_mem_en) begin
         if (b_mem_we) begin
            for (int k = 0; k < 4; k++) begin
               if (b_mem_be[k]) mem_b[b_mem_addr][8*k +: 8] <= b_mem_wdata[8*k +: 8];
            end
         end
         b_pipe0 <= mem_b[b_mem_addr];
      end else begin
         b_pipe0 <= 32'hBAD0_BAD0;
      end
   end
   assign a_mem_rdata = a_pipe1;
   assign b_mem_rdata = b_pipe0;

   function automatic logic [31:0] init_word(input logic [9:0] a);
      return 32'hC0DE_0000 | {22'd0, a};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack_a(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(a_if_ack || a_d_ack) && n < 20);
   endtask

   task automatic wait_ack_b(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(b_if_ack || b_d_ack) && n < 20);
   endtask

   initial begin
      int n;
      int acks;
      int prev;
      logic exp_if [6];
      compared   = 0;
      mismatched = 0;
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = init_word(10'(i));
         mem_b[i] = init_word(10'(i));
      end
      mem_a[10'h010] = 32'h0050_0093;
      reset    = 1'b1;
      a_if_req = 1'b0; a_if_addr = 10'd0; a_d_req = 1'b0; a_d_we = 1'b0;
      a_d_be   = 4'd0; a_d_addr = 10'd0;  a_d_wdata = 32'd0;
      b_if_req = 1'b0; b_if_addr = 10'd0; b_d_req = 1'b0; b_d_we = 1'b0;
      b_d_be   = 4'd0; b_d_addr = 10'd0;  b_d_wdata = 32'd0;
      tick(); tick(); tick();

      chk("rst_a_ctl", 64'({a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_mem_be, a_busy}), 64'd0);
      chk("rst_a_rd",  64'({a_if_rdata, a_d_rdata}), 64'd0);
      chk("rst_a_mem", 64'({a_mem_addr, a_mem_wdata}), 64'd0);
      chk("rst_b_ctl", 64'({b_if_ack, b_d_ack, b_mem_en, b_busy}), 64'd0);
      reset = 1'b0;
      tick();

      // Single fetch, latency 2: mem_en in c1, ack only in c4.
      a_if_addr = 10'h010; a_if_req = 1'b1;
      tick();
      chk("t1_c1_mem", 64'({a_mem_en, a_mem_we, a_mem_addr}), 64'({1'b1, 1'b0, 10'h010}));
      chk("t1_c1_ack", 64'(a_if_ack), 64'd0);
      tick();
      chk("t1_c2_ack", 64'({a_if_ack, a_mem_en}), 64'd0);
      tick();
      chk("t1_c3_ack", 64'(a_if_ack), 64'd0);
      tick();
      chk("t1_c4_ack", 64'({a_if_ack, a_d_ack}), 64'b10);
      chk("t1_c4_rdata", 64'(a_if_rdata), 64'h0050_0093);
      a_if_req = 1'b0;
      tick();
      chk("t1_c5_idle", 64'({a_if_ack, a_busy}), 64'd0);

      // Latency-1 instance: load, byte-masked store, reload.
      b_d_addr = 10'h3FF; b_d_we = 1'b0; b_d_req = 1'b1;
      wait_ack_b(n);
      chk("t2_load_lat", 64'(n), 64'd3);
      chk("t2_load_data", 64'(b_d_rdata), 64'hC0DE_03FF);
      b_d_req = 1'b0;
      tick();
      b_d_we = 1'b1; b_d_be = 4'b0011; b_d_wdata = 32'hDEAD_BEEF; b_d_req = 1'b1;
      tick();
      chk("t2_c1_mem", 64'({b_mem_en, b_mem_we, b_mem_be, b_mem_addr}), 64'h0000_CFFF);
      chk("t2_c1_wdata", 64'(b_mem_wdata), 64'hDEAD_BEEF);
      tick();
      chk("t2_c2_ack", 64'({b_d_ack, b_if_ack, b_mem_en}), 64'd0);
      tick();
      chk("t2_c3_ack", 64'({b_d_ack, b_if_ack}), 64'b10);
      chk("t2_c3_rdata_kept", 64'(b_d_rdata), 64'hC0DE_03FF);
      b_d_req = 1'b0; b_d_we = 1'b0; b_d_be = 4'd0;
      tick();
      b_d_req = 1'b1;
      wait_ack_b(n);
      chk("t2_reload", 64'(b_d_rdata), 64'hC0DE_BEEF);
      b_d_req = 1'b0;
      tick();

      // Starve limit 0: both held, data always wins.
      b_if_addr = 10'h050; b_d_addr = 10'h051; b_if_req = 1'b1; b_d_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_ack_b(n);
         chk("t4b_gnt", 64'({b_if_ack, b_d_ack}), 64'b01);
      end
      chk("t4b_data", 64'(b_d_rdata), 64'hC0DE_0051);
      b_if_req = 1'b0; b_d_req = 1'b0;
      tick();

      // Simultaneous rise: data first, fetch in the next transaction.
      a_if_addr = 10'h030; a_d_addr = 10'h031; a_d_we = 1'b0;
      a_if_req = 1'b1; a_d_req = 1'b1;
      wait_ack_a(n);
      chk("t3_first_lat", 64'(n), 64'd4);
      chk("t3_first_gnt", 64'({a_if_ack, a_d_ack}), 64'b01);
      chk("t3_first_data", 64'(a_d_rdata), 64'hC0DE_0031);
      a_d_req = 1'b0;
      wait_ack_a(n);
      chk("t3_second_lat", 64'(n), 64'd5);
      chk("t3_second_gnt", 64'({a_if_ack, a_d_ack}), 64'b10);
      chk("t3_second_data", 64'(a_if_rdata), 64'hC0DE_0030);
      a_if_req = 1'b0;
      tick();

      // Both held continuously, starve limit 2: D,D,IF,D,D,IF.
      exp_if = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      a_if_addr = 10'h040; a_d_addr = 10'h041; a_if_req = 1'b1; a_d_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_ack_a(n);
         chk("t4_spacing", 64'(n), (i == 0) ? 64'd4 : 64'd5);
         chk("t4_gnt", 64'({a_if_ack, a_d_ack}), exp_if[i] ? 64'b10 : 64'b01);
         if (exp_if[i]) begin
            chk("t4_if_data", 64'(a_if_rdata), 64'hC0DE_0040);
         end else begin
            chk("t4_d_data", 64'(a_d_rdata), 64'hC0DE_0041);
         end
      end
      a_if_req = 1'b0; a_d_req = 1'b0;
      tick();

      // Streaming fetch with incrementing addresses.
      a_if_addr = 10'h100; a_if_req = 1'b1;
      acks = 0;
      prev = -1;
      for (int c = 0; c < 40 && acks < 4; c++) begin
         tick();
         if (a_mem_en) begin
            if (prev >= 0) chk("t6_spacing", 64'(c - prev), 64'd5);
            prev = c;
         end
         if (a_if_ack) begin
            chk("t6_rdata", 64'(a_if_rdata), 64'(init_word(a_if_addr)));
            acks++;
            a_if_addr = a_if_addr + 10'd1;
         end
      end
      a_if_req = 1'b0;
      chk("t6_acks", 64'(acks), 64'd4);
      tick();

      // Reset during WAIT of a load aborts it silently.
      a_d_addr = 10'h020; a_d_we = 1'b0; a_d_req = 1'b1;
      tick();
      chk("t5_c1_en", 64'(a_mem_en), 64'd1);
      tick();
      chk("t5_c2_busy", 64'(a_busy), 64'd1);
      reset = 1'b1; a_d_req = 1'b0;
      tick();
      chk("t5_rst_ctl", 64'({a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_mem_be, a_busy}), 64'd0);
      chk("t5_rst_rd",  64'({a_if_rdata, a_d_rdata}), 64'd0);
      chk("t5_rst_mem", 64'({a_mem_addr, a_mem_wdata}), 64'd0);
      reset = 1'b0;
      tick();
      chk("t5_after1", 64'({a_d_ack, a_busy}), 64'd0);
      tick();
      chk("t5_after2", 64'({a_d_ack, a_d_rdata}), 64'd0);
      a_d_req = 1'b1;
      wait_ack_a(n);
      chk("t5_fresh_lat", 64'(n), 64'd4);
      chk("t5_fresh_gnt", 64'({a_if_ack, a_d_ack}), 64'b01);
      chk("t5_fresh_data", 64'(a_d_rdata), 64'hC0DE_0020);
      a_d_req = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
